// File: rtl/display_source_mux_if.sv
// Bus bundle for display_source_mux: controller requests, channel inputs and
// the registered display outputs. The master side drives the controls and
// channel data. The slave side is the mux itself.
interface display_source_mux_if #(
  parameter int DATA_W = 4,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
);
  logic                     mode;
  logic                     hold;
  logic [SEL_W-1:0]         sel_in;
  logic [NUM_CH-1:0]        ch_enable;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [DATA_W-1:0]        data_out;
  logic [SEL_W-1:0]         cur_ch;
  logic                     switched;

  modport master (
    output mode, hold, sel_in, ch_enable, ch_data,
    input  data_out, cur_ch, switched
  );

  modport slave (
    input  mode, hold, sel_in, ch_enable, ch_data,
    output data_out, cur_ch, switched
  );
endinterface

// File: rtl/display_source_mux.sv
// display_source_mux: registered N-channel selector feeding the digit display.
// It has three modes:
//   - Manual: the controller picks the channel.
//   - Auto-scan: the mux rotates through the enabled channels, with a dwell of
//     DWELL_CYCLES per channel.
//   - Hold: freezes the output, the channel and the dwell count.
// Optional build macro DISPLAY_MUX_BLANK_EN: when defined, data_out shows
// all-ones (the blank code) on each cycle where switched pulses.
module display_source_mux #(
  parameter int DATA_W       = 4,
  parameter int NUM_CH       = 4,
  parameter int SEL_W        = 2,
  parameter int DWELL_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  display_source_mux_if.slave  bus
);

  localparam int              CNT_W    = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {S_MANUAL, S_AUTO, S_FROZEN} state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    cur_ch_q, cur_ch_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                switched_q, switched_d;

  logic [SEL_W-1:0]    nxt_ch;
  logic                cur_en;
  logic                none_en;

  // Circular search for the first enabled channel after cur. The search
  // covers all channels and ends on cur itself, so a lone enabled channel
  // maps back to itself.
  function automatic logic [SEL_W-1:0] next_enabled(input logic [SEL_W-1:0] cur,
                                                    input logic [NUM_CH-1:0] en);
    logic [SEL_W-1:0] res;
    int               idx;
    res = cur;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = int'(cur) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (|(en & (NUM_CH'(1) << idx))) res = SEL_W'(idx);
    end
    return res;
  endfunction

  // Pick the DATA_W-wide slice of the packed channel bus for channel idx.
  function automatic logic [DATA_W-1:0] chan_value(input logic [SEL_W-1:0] idx,
                                                   input logic [NUM_CH*DATA_W-1:0] data);
    return DATA_W'(data >> (int'(idx) * DATA_W));
  endfunction

  assign nxt_ch  = next_enabled(cur_ch_q, bus.ch_enable);
  assign cur_en  = |(bus.ch_enable & (NUM_CH'(1) << cur_ch_q));
  assign none_en = (bus.ch_enable == '0);

  // Next-state: hold beats auto, and auto beats manual. Frozen leaves everything as is.
  always_comb begin
    state_d    = state_q;
    cur_ch_d   = cur_ch_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    switched_d = 1'b0;
    if (bus.hold) begin
      state_d = S_FROZEN;
    end else if (bus.mode) begin
      state_d = S_AUTO;
      if (none_en) begin
        cnt_d = '0;
      end else if (!cur_en) begin
        // Current channel was disabled: move on now, without waiting for the dwell to expire.
        cur_ch_d = nxt_ch;
        cnt_d    = '0;
      end else if (state_q == S_MANUAL) begin
        // Fresh entry into scanning starts a full dwell on the current channel.
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d    = '0;
        cur_ch_d = nxt_ch;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      state_d = S_MANUAL;
      cnt_d   = '0;
      if (32'(bus.sel_in) < NUM_CH) cur_ch_d = bus.sel_in;
    end

    if (!bus.hold) begin
      switched_d = (cur_ch_d != cur_ch_q);
      data_d     = (bus.mode && none_en) ? '0 : chan_value(cur_ch_d, bus.ch_data);
`ifdef DISPLAY_MUX_BLANK_EN
      if (switched_d) data_d = '1;
`endif
    end
  end

  // State, channel, dwell counter and all outputs are registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_MANUAL;
      cur_ch_q   <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      switched_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_ch_q   <= cur_ch_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      switched_q <= switched_d;
    end
  end

  assign bus.data_out = data_q;
  assign bus.cur_ch   = cur_ch_q;
  assign bus.switched = switched_q;

endmodule

// File: tb/tb_display_source_mux.sv
// Testbench for display_source_mux. It runs a set of directed scenarios and
// then randomized traffic. A behavioural model checks the outputs every cycle.
module tb_display_source_mux;

  localparam int DW    = 4;
  localparam int NCH   = 4;
  localparam int SW    = 3;
  localparam int DWELL = 4;
`ifdef DISPLAY_MUX_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  display_source_mux_if #(.DATA_W(DW), .NUM_CH(NCH), .SEL_W(SW)) bus ();

  display_source_mux #(.DATA_W(DW), .NUM_CH(NCH), .SEL_W(SW), .DWELL_CYCLES(DWELL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  int ch_val [NCH];

  // Reference model state.
  int m_cur, m_cnt, m_data, m_mode_prev;  // m_mode_prev: 0 manual, 1 auto, 2 frozen
  bit m_sw;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_data();
    bus.ch_data = {4'(ch_val[3]), 4'(ch_val[2]), 4'(ch_val[1]), 4'(ch_val[0])};
  endtask

  // Next enabled channel after cur, wrapping around (en must be non-zero).
  function automatic int scan_next(input int cur, input logic [NCH-1:0] en);
    int q[$];
    int res;
    bit found;
    for (int c = 0; c < NCH; c++) if (en[c]) q.push_back(c);
    res = q[0];
    found = 0;
    for (int j = 0; j < q.size(); j++)
      if (!found && q[j] > cur) begin res = q[j]; found = 1; end
    return res;
  endfunction

  // Advance the model by one clock, using the inputs currently applied.
  task automatic model_step();
    int newcur;
    logic [NCH-1:0] en;
    en = bus.ch_enable;
    if (bus.hold) begin
      m_sw = 0;
      m_mode_prev = 2;
      return;
    end
    newcur = m_cur;
    if (!bus.mode) begin
      if (int'(bus.sel_in) < NCH) newcur = int'(bus.sel_in);
      m_cnt = 0;
      m_mode_prev = 0;
    end else begin
      if (en == 0) m_cnt = 0;
      else if (!en[m_cur]) begin newcur = scan_next(m_cur, en); m_cnt = 0; end
      else if (m_mode_prev == 0) m_cnt = 0;
      else if (m_cnt == DWELL - 1) begin newcur = scan_next(m_cur, en); m_cnt = 0; end
      else m_cnt = m_cnt + 1;
      m_mode_prev = 1;
    end
    m_sw   = (newcur != m_cur);
    m_cur  = newcur;
    m_data = (en == 0) && bus.mode ? 0 : ch_val[m_cur];
    if (BLANK && m_sw) m_data = 15;
  endtask

  // Apply the current inputs for one clock, then compare the DUT against the model on the falling edge.
  task automatic tick();
    model_step();
    @(negedge clk);
    check("cur_ch",   32'(bus.cur_ch),   32'(m_cur));
    check("data_out", 32'(bus.data_out), 32'(m_data));
    check("switched", 32'(bus.switched), 32'(m_sw));
  endtask

  // Assert the asynchronous reset between clock edges, check the outputs at once, then release it.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst data_out", 32'(bus.data_out), 0);
    check("rst cur_ch",   32'(bus.cur_ch),   0);
    check("rst switched", 32'(bus.switched), 0);
    m_cur = 0; m_cnt = 0; m_data = 0; m_sw = 0; m_mode_prev = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int seq_ch  [4] = '{0, 1, 3, 0};
  int seq_val [4] = '{5, 1, 3, 5};

  initial begin
    bus.mode = 0; bus.hold = 0; bus.sel_in = '0; bus.ch_enable = '0;
    ch_val = '{5, 1, 2, 3};
    drive_data();
    @(negedge clk);
    do_reset();

    // Manual select, then a mid-run reset, then manual select of channel 2 and an out-of-range request.
    bus.sel_in = 3'd3; tick(); tick();
    do_reset();
    bus.sel_in = 3'd2; tick();
    check("man cur", 32'(bus.cur_ch), 2);
    check("man data", 32'(bus.data_out), BLANK ? 15 : 2);
    check("man sw", 32'(bus.switched), 1);
    bus.sel_in = 3'd7; tick();
    check("man oob cur", 32'(bus.cur_ch), 2);
    check("man oob sw", 32'(bus.switched), 0);

    // Auto scan with ch2 disabled: 0,1,3,0, four cycles each.
    bus.sel_in = 3'd0; tick();
    bus.mode = 1; bus.ch_enable = 4'b1011;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("scan cur", 32'(bus.cur_ch), 32'(seq_ch[i/4]));
      check("scan data", 32'(bus.data_out),
            (BLANK && (i % 4 == 0) && i > 0) ? 32'd15 : 32'(seq_val[i/4]));
    end

    // Enable of ch1 drops at count 1.
    bus.mode = 0; bus.sel_in = 3'd1; tick();
    bus.mode = 1; tick(); tick();
    bus.ch_enable = 4'b1001; tick();
    check("drop cur", 32'(bus.cur_ch), 3);
    check("drop sw", 32'(bus.switched), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("drop dwell", 32'(bus.cur_ch), 3);
    end
    bus.ch_enable = 4'b1011; tick();
    check("drop wrap", 32'(bus.cur_ch), 0);

    // Hold at count 2 on ch0 while ch0's data changes.
    tick(); tick();
    bus.hold = 1; ch_val[0] = 9; drive_data();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold data", 32'(bus.data_out), 5);
      check("hold cur", 32'(bus.cur_ch), 0);
    end
    bus.hold = 0; tick();
    check("resume data", 32'(bus.data_out), 9);
    check("resume cur", 32'(bus.cur_ch), 0);
    tick();
    check("resume switch", 32'(bus.cur_ch), 1);

    // No channel enabled, then ch2 is enabled again.
    bus.ch_enable = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("none data", 32'(bus.data_out), 0);
      check("none cur", 32'(bus.cur_ch), 1);
      check("none sw", 32'(bus.switched), 0);
    end
    bus.ch_enable = 4'b0100; tick();
    check("reen cur", 32'(bus.cur_ch), 2);
    check("reen data", 32'(bus.data_out), BLANK ? 15 : 2);

    // Manual switch from ch0 to ch3, where the blanking cycle shows up when that option is enabled.
    ch_val[0] = 5; drive_data();
    bus.mode = 0; bus.sel_in = 3'd0; tick(); tick();
    bus.sel_in = 3'd3; tick();
    check("blank sw data", 32'(bus.data_out), BLANK ? 15 : 3);
    tick();
    check("blank after", 32'(bus.data_out), 3);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      bus.hold   = ($urandom_range(0, 9) == 0);
      bus.mode   = ($urandom_range(0, 3) != 0);
      bus.sel_in = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) bus.ch_enable = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        ch_val[$urandom_range(0, NCH-1)] = int'($urandom_range(0, 15));
        drive_data();
      end
      if ($urandom_range(0, 149) == 0) do_reset();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
